// File: rtl/game_controller.sv
// Battleship game sequencer: one-hot phase strobes decoded from state, player turn timer, metered PC attack.
// Latency: 1 cycle from sampled flag/press to next phase; no backpressure, board flags are level inputs.
module game_controller #(
  parameter int unsigned CLK_HZ          = 25_000_000,
  parameter int unsigned TURN_SECONDS    = 15,
  parameter int unsigned PC_DELAY_CYCLES = 25_000_000,
  parameter int unsigned MAX_SHIPS       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_button,
  input  logic [2:0] ship_count_sw,
  input  logic       finished_placing,
  input  logic       finished_setUp,
  input  logic       player_has_move,
  input  logic       pc_has_move,
  input  logic       pc_ships_zero,
  input  logic       player_ships_zero,
  output logic       colocation_ships_State,
  output logic       setup_State,
  output logic       player_turn_State,
  output logic       pc_turn_State,
  output logic       win_State,
  output logic       lose_State,
  output logic [2:0] player_ship_amount_define,
  output logic [4:0] seconds_left,
  output logic       turn_timeout,
  output logic [2:0] game_state
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DW = (PC_DELAY_CYCLES > 1) ? $clog2(PC_DELAY_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'(PC_DELAY_CYCLES - 1);
  localparam logic [4:0]    SEC_LOAD = 5'(TURN_SECONDS);
  localparam logic [2:0]    SHIP_MAX = 3'(MAX_SHIPS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLACE   = 3'd1,
    SETUP   = 3'd2,
    PLAYER  = 3'd3,
    PC_WAIT = 3'd4,
    PC_FIRE = 3'd5,
    WIN     = 3'd6,
    LOSE    = 3'd7
  } state_t;

  state_t        state;
  logic          btn_prev;
  logic [PW-1:0] prescaler;
  logic [DW-1:0] delay_cnt;
  logic          press;
  logic          tick;
  logic [2:0]    ship_clamped;

  // Button history resets high, so a button held low out of reset counts as one press.
  assign press = btn_prev & ~start_button;
  assign tick  = (prescaler == PRE_LAST);

  always_comb begin
    ship_clamped = ship_count_sw;
    if (ship_count_sw == 3'd0)
      ship_clamped = 3'd1;
    else if (ship_count_sw > SHIP_MAX)
      ship_clamped = SHIP_MAX;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                     <= IDLE;
      btn_prev                  <= 1'b1;
      prescaler                 <= '0;
      delay_cnt                 <= '0;
      seconds_left              <= 5'd0;
      turn_timeout              <= 1'b0;
      player_ship_amount_define <= 3'd1;
    end else begin
      btn_prev     <= start_button;
      turn_timeout <= 1'b0;
      case (state)
        IDLE: if (press) begin
          state                     <= PLACE;
          player_ship_amount_define <= ship_clamped;
        end
        PLACE: if (finished_placing) state <= SETUP;
        SETUP: if (finished_setUp) begin
          state        <= PLAYER;
          seconds_left <= SEC_LOAD;
          prescaler    <= '0;
        end
        PLAYER: begin
          prescaler <= tick ? '0 : prescaler + 1'b1;
          if (pc_ships_zero) begin
            state        <= WIN;
            seconds_left <= 5'd0;
          end else if (player_has_move) begin
            state        <= PC_WAIT;
            seconds_left <= 5'd0;
            delay_cnt    <= '0;
          end else if (tick) begin
            if (seconds_left <= 5'd1) begin
              state        <= PC_WAIT;
              seconds_left <= 5'd0;
              delay_cnt    <= '0;
              turn_timeout <= 1'b1;
            end else begin
              seconds_left <= seconds_left - 5'd1;
            end
          end
        end
        PC_WAIT: begin
          if (pc_ships_zero)
            state <= WIN;
          else if (delay_cnt == DLY_LAST)
            state <= PC_FIRE;
          else
            delay_cnt <= delay_cnt + 1'b1;
        end
        // A PC shot at an already-hit cell leaves pc_has_move low; keep firing until it lands.
        PC_FIRE: begin
          if (pc_ships_zero)
            state <= WIN;
          else if (player_ships_zero)
            state <= LOSE;
          else if (pc_has_move) begin
            state        <= PLAYER;
            seconds_left <= SEC_LOAD;
            prescaler    <= '0;
          end
        end
        default: state <= state;
      endcase
    end
  end

  assign colocation_ships_State = (state == PLACE);
  assign setup_State            = (state == SETUP);
  assign player_turn_State      = (state == PLAYER);
  assign pc_turn_State          = (state == PC_FIRE);
  assign win_State              = (state == WIN);
  assign lose_State             = (state == LOSE);
  assign game_state             = state;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed game scenarios plus random stimulus, scored against an elapsed-cycle reference model.
module tb_game_controller;

  localparam int CLK_HZ = 4;
  localparam int T_SEC  = 3;
  localparam int DELAY  = 2;
  localparam int MAXS   = 5;

  logic       clk = 1'b0;
  logic       rst, start_button;
  logic [2:0] ship_count_sw;
  logic       finished_placing, finished_setUp, player_has_move, pc_has_move;
  logic       pc_ships_zero, player_ships_zero;
  logic       colocation_ships_State, setup_State, player_turn_State, pc_turn_State;
  logic       win_State, lose_State, turn_timeout;
  logic [2:0] player_ship_amount_define, game_state;
  logic [4:0] seconds_left;

  game_controller #(
    .CLK_HZ(CLK_HZ), .TURN_SECONDS(T_SEC), .PC_DELAY_CYCLES(DELAY), .MAX_SHIPS(MAXS)
  ) dut (
    .clk(clk), .rst(rst), .start_button(start_button), .ship_count_sw(ship_count_sw),
    .finished_placing(finished_placing), .finished_setUp(finished_setUp),
    .player_has_move(player_has_move), .pc_has_move(pc_has_move),
    .pc_ships_zero(pc_ships_zero), .player_ships_zero(player_ships_zero),
    .colocation_ships_State(colocation_ships_State), .setup_State(setup_State),
    .player_turn_State(player_turn_State), .pc_turn_State(pc_turn_State),
    .win_State(win_State), .lose_State(lose_State),
    .player_ship_amount_define(player_ship_amount_define), .seconds_left(seconds_left),
    .turn_timeout(turn_timeout), .game_state(game_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] strobes;
    logic [4:0] sec;
    logic       to;
    logic [2:0] amt;
  } exp_t;

  exp_t scb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: game phase plus elapsed edge counts in the timed phases.
  int   m_state = 0, m_amt = 1, m_btn = 1, m_pcyc = 0, m_wcyc = 0, m_to = 0;

  task automatic model_edge();
    int press;
    if (!rst) begin
      m_state = 0; m_amt = 1; m_btn = 1; m_pcyc = 0; m_wcyc = 0; m_to = 0;
    end else begin
      press   = (m_btn == 1 && start_button == 1'b0) ? 1 : 0;
      m_btn   = int'(start_button);
      m_to    = 0;
      case (m_state)
        0: if (press == 1) begin
             m_state = 1;
             m_amt   = (ship_count_sw == 0) ? 1 : (int'(ship_count_sw) > MAXS ? MAXS : int'(ship_count_sw));
           end
        1: if (finished_placing) m_state = 2;
        2: if (finished_setUp) begin m_state = 3; m_pcyc = 0; end
        3: begin
             m_pcyc++;
             if (pc_ships_zero) m_state = 6;
             else if (player_has_move) begin m_state = 4; m_wcyc = 0; end
             else if (m_pcyc == T_SEC * CLK_HZ) begin m_state = 4; m_wcyc = 0; m_to = 1; end
           end
        4: begin
             if (pc_ships_zero) m_state = 6;
             else begin
               m_wcyc++;
               if (m_wcyc == DELAY) m_state = 5;
             end
           end
        5: begin
             if (pc_ships_zero) m_state = 6;
             else if (player_ships_zero) m_state = 7;
             else if (pc_has_move) begin m_state = 3; m_pcyc = 0; end
           end
        default: ;
      endcase
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.st      = 3'(m_state);
    e.strobes = {m_state == 1, m_state == 2, m_state == 3, m_state == 5, m_state == 6, m_state == 7};
    e.sec     = (m_state == 3) ? 5'(T_SEC - m_pcyc / CLK_HZ) : 5'd0;
    e.to      = (m_to == 1);
    e.amt     = 3'(m_amt);
    return e;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    scb.push_back(model_out());
    cyc++;
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (scb.size() != 0) begin
      e = scb.pop_front();
      check("game_state", 32'(game_state), 32'(e.st));
      check("strobes", 32'({colocation_ships_State, setup_State, player_turn_State,
                            pc_turn_State, win_State, lose_State}), 32'(e.strobes));
      check("seconds_left", 32'(seconds_left), 32'(e.sec));
      check("turn_timeout", 32'(turn_timeout), 32'(e.to));
      check("ship_amount", 32'(player_ship_amount_define), 32'(e.amt));
    end
  end

  task automatic clear_flags();
    finished_placing = 0; finished_setUp = 0; player_has_move = 0;
    pc_has_move = 0; pc_ships_zero = 0; player_ships_zero = 0;
  endtask

  task automatic idle(int n);
    clear_flags();
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 0; start_button = 1; clear_flags();
    cycle(); cycle();
    rst = 1;
  endtask

  task automatic press(logic [2:0] sw);
    ship_count_sw = sw; start_button = 0;
    cycle();
    start_button = 1;
  endtask

  task automatic pulse_fp();   finished_placing = 1; cycle(); finished_placing = 0; endtask
  task automatic pulse_fs();   finished_setUp   = 1; cycle(); finished_setUp   = 0; endtask
  task automatic pulse_phm();  player_has_move  = 1; cycle(); player_has_move  = 0; endtask
  task automatic pulse_pchm(); pc_has_move      = 1; cycle(); pc_has_move      = 0; endtask

  initial begin
    rst = 0; start_button = 1; ship_count_sw = 0; clear_flags();

    // Reset and ship-count clamp at both ends
    do_reset(); press(3'd0); idle(2);
    do_reset(); press(3'd7); idle(1);

    // Full turn: place, setup, player move, PC delay, PC hit
    pulse_fp(); idle(1); pulse_fs(); idle(3); pulse_phm(); idle(3); pulse_pchm();

    // Timeout with no player move, then back to player
    idle(14); pulse_pchm();

    // Move on the exact timeout edge, then win beating a simultaneous move
    idle(11); pulse_phm(); idle(2); pulse_pchm();
    pc_ships_zero = 1; player_has_move = 1; cycle(); clear_flags();
    press(3'd3); idle(1); press(3'd3); idle(2);

    // Stuck PC fire, then loss that holds through presses
    do_reset(); press(3'd4); pulse_fp(); pulse_fs(); pulse_phm(); idle(12);
    player_ships_zero = 1; cycle(); player_ships_zero = 0;
    press(3'd2); idle(1); press(3'd2); idle(2);

    // Mid-game reset while the PC is thinking
    do_reset(); press(3'd2); pulse_fp(); pulse_fs(); pulse_phm(); idle(1);
    rst = 0; cycle(); rst = 1; idle(3);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      rst               = (m_state >= 6) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 199) != 0);
      start_button      = 1'($urandom_range(0, 1));
      ship_count_sw     = 3'($urandom_range(0, 7));
      finished_placing  = ($urandom_range(0, 3) == 0);
      finished_setUp    = ($urandom_range(0, 3) == 0);
      player_has_move   = ($urandom_range(0, 11) == 0);
      pc_has_move       = ($urandom_range(0, 2) == 0);
      pc_ships_zero     = ($urandom_range(0, 79) == 0);
      player_ships_zero = ($urandom_range(0, 59) == 0);
      cycle();
    end

    clear_flags();
    @(negedge clk); @(negedge clk);
    check("scoreboard_drained", 32'(scb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level game sequencer for the Battleship board. It drives the mutually exclusive phase strobes that the board datapath consumes: ship placement, PC setup, player turn and PC turn. It watches the board's status flags to advance through the game and enforces a per-turn timeout for the player. It also meters the PC's attack, so that the board's PC-attack branch fires exactly once per PC turn.

## Interface
Parameters:
- CLK_HZ, 25_000_000: cycles per second; sets the prescaler period.
- TURN_SECONDS, 15: player turn budget in seconds, range 1..31.
- PC_DELAY_CYCLES, 25_000_000: cycles the PC "thinks" before firing, minimum 1.
- MAX_SHIPS, 5: upper clamp on the ship count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start_button  in  1  raw button; press event = sampled 1 last cycle, 0 this cycle.
- ship_count_sw  in  3  requested ship count.
- finished_placing, finished_setUp  in  1  board phase-done flags.
- player_has_move, pc_has_move  in  1  board flags: the respective side has attacked this turn.
- pc_ships_zero, player_ships_zero  in  1  board flags: the respective fleet is sunk.
- colocation_ships_State, setup_State, player_turn_State, pc_turn_State  out  1  phase strobes to the board.
- win_State, lose_State  out  1  terminal indicators.
- player_ship_amount_define  out  3  latched ship count, range 1..MAX_SHIPS.
- seconds_left  out  5  player turn countdown, for display.
- turn_timeout  out  1  one-cycle pulse when the player forfeits a turn.
- game_state  out  3  current state code.

## Operation
State codes: IDLE=0, PLACE=1, SETUP=2, PLAYER=3, PC_WAIT=4, PC_FIRE=5, WIN=6, LOSE=7.

Phase strobes are decoded combinationally from the state:
- PLACE → colocation_ships_State.
- SETUP → setup_State.
- PLAYER → player_turn_State.
- PC_FIRE → pc_turn_State.
- WIN → win_State.
- LOSE → lose_State.
- At most one strobe is high at any time.

Transitions (evaluated each rising edge):
- IDLE → PLACE on a start_button press.
  - On the same edge, latch ship_count_sw clamped: 0→1, values >MAX_SHIPS→MAX_SHIPS, otherwise unchanged.
- PLACE → SETUP when finished_placing=1.
- SETUP → PLAYER when finished_setUp=1.
  - Load seconds_left=TURN_SECONDS and clear the prescaler.
- PLAYER exits, in priority order:
  1. pc_ships_zero → WIN.
  2. player_has_move → PC_WAIT.
  3. Timeout tick → PC_WAIT, with turn_timeout=1 for that one cycle.
- PC_WAIT: a delay counter is cleared on entry.
  - Goes to PC_FIRE after exactly PC_DELAY_CYCLES cycles in PC_WAIT.
  - If pc_ships_zero → WIN, with priority over the delay.
- PC_FIRE exits, in priority order:
  1. pc_ships_zero → WIN.
  2. player_ships_zero → LOSE.
  3. pc_has_move → PLAYER, reloading seconds_left and the prescaler.
  - With none of these, stay in PC_FIRE. This covers a random target that was already hit, where the board does nothing.
- WIN and LOSE hold until rst. Button presses are ignored there.
- start_button is ignored in every state except IDLE.

## Timing
- Reset (rst=0 at an edge) puts the block in IDLE. All strobes, seconds_left, turn_timeout, the prescaler and the delay counter go to 0; player_ship_amount_define goes to 1; the button history register goes to 1.
  - Reset mid-game takes effect at that edge regardless of state.
- Inputs are sampled at the rising edge. The board updates on the falling edge, so its flags are visible one half-cycle after a strobe rises.
- Prescaler:
  - Counts 0..CLK_HZ-1 and only runs in PLAYER.
  - A tick is the cycle where prescaler==CLK_HZ-1.
  - Each tick decrements seconds_left.
  - A tick while seconds_left==1 is the timeout; seconds_left becomes 0.
- In the same cycle, player_has_move beats timeout, and pc_ships_zero beats both.
- seconds_left reads 0 outside PLAYER.
- The PC_FIRE dwell time is normally 1 cycle: pc_has_move rises at the falling edge within that cycle.
- Latency:
  - Start press to colocation_ships_State high: 1 cycle.
  - Flag high to next strobe: 1 cycle.
- The press detector needs a 1→0 sample pair. Holding the button low never re-triggers.

## Test plan
Bench parameters: CLK_HZ=4, TURN_SECONDS=3, PC_DELAY_CYCLES=2.

- **Reset and clamp:** rst low 2 cycles, then ship_count_sw=0 and a start press.
  - Response: state 0→1; player_ship_amount_define=1.
  - Repeat with sw=7: amount=5.
- **Full turn cycle:**
  - Stimulus: assert finished_placing, then finished_setUp.
  - Response: PLACE→SETUP→PLAYER, with seconds_left=3.
  - Stimulus: pulse player_has_move.
  - Response: PC_WAIT for exactly 2 cycles, then pc_turn_State high.
  - Stimulus: pc_has_move=1.
  - Response: PLAYER next cycle, with seconds_left=3.
- **Timeout:** no move in PLAYER.
  - seconds_left goes 3→2→1 at 4-cycle intervals.
  - On the 12th cycle, turn_timeout pulses once and the state becomes PC_WAIT.
- **Simultaneous events:** player_has_move and the timeout tick in the same cycle → turn_timeout stays 0 and the state goes to PC_WAIT.
  - Separately: pc_ships_zero together with player_has_move → WIN.
- **Stuck PC and loss:**
  - Hold pc_has_move=0 in PC_FIRE for 10 cycles → pc_turn_State stays high.
  - Then player_ships_zero=1 → LOSE, which holds through start presses.
- **Mid-game reset:** rst low while in PC_WAIT → IDLE, all outputs at their reset values, and amount=1 on the next cycle.
